// File: rtl/datapath_mc_if.sv
// Memory-side bus bundle for datapath_mc: instruction fetch and data access
// request/acknowledge handshakes.
//   imem_req/imem_addr   : fetch request and word address (core -> memory)
//   imem_rdata/imem_ack  : fetched instruction and its acknowledge (memory -> core)
//   dmem_req/dmem_we     : data request and write strobe (core -> memory)
//   dmem_addr/dmem_wdata : data address and store data (core -> memory)
//   dmem_rdata/dmem_ack  : load data and its acknowledge (memory -> core)
`timescale 1ns/1ps
interface datapath_mc_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/datapath_mc.sv
// Multi-cycle RV32I-style datapath. An external decoder looks at
// opcode/func3/func7 and returns the control strobes; this block owns the
// PC, IR, register file, ALU, branch compare and the sequencing FSM.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   MemtoReg..bgeu        : decoded controls, valid in EX/MEM/WB
//   mem_read, mem_write   : instruction is a load / store
//   ALUctl                : 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt,
//                           6 sltu, 7 sll, 8 srl, 9 sra (others add)
//   opcode, func3, func7  : IR fields for the decoder (func7 = IR[30])
//   mem                   : fetch/data handshake bundle (master side)
//   trap, trap_pc         : misaligned-target trap pulse and faulting PC
//   instret               : retired-instruction counter (wraps)
//
// state | meaning
// IDLE  | one idle cycle after reset
// FETCH | imem request at PC, wait for ack, load IR
// EX    | decode, ALU, branch compare, compute next PC
// MEM   | data request, wait for ack, latch load data
// WB    | register write, PC update, retire
// TRAP  | misaligned target: record PC, redirect to TRAP_PC
`timescale 1ns/1ps
module datapath_mc #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC       = 32'h0000_0100,
    parameter bit          MISALIGN_TRAP = 1'b1,
    parameter int          CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemtoReg,
    input  logic             ALUSrc,
    input  logic             RegWrite,
    input  logic             lui,
    input  logic             U_type,
    input  logic             jal,
    input  logic             jalr,
    input  logic             beq,
    input  logic             bne,
    input  logic             blt,
    input  logic             bge,
    input  logic             bltu,
    input  logic             bgeu,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [3:0]       ALUctl,
    output logic [6:0]       opcode,
    output logic [2:0]       func3,
    output logic             func7,
    datapath_mc_if.master    mem,
    output logic             trap,
    output logic [31:0]      trap_pc,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EX    = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_TRAP  = 3'd5;

    localparam logic [31:0]      IR_NOP  = 32'h0000_0013;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      alu_q, alu_d;
    logic [31:0]      rs2_q, rs2_d;
    logic [31:0]      pc4_q, pc4_d;
    logic [31:0]      pcimm_q, pcimm_d;
    logic [31:0]      npc_q, npc_d;
    logic             st_q, st_d;
    logic [31:0]      ld_q, ld_d;
    logic [31:0]      trap_pc_q, trap_pc_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [31:0] rf_q [32];

    logic [4:0]  rd, rs1_a, rs2_a;
    logic [31:0] rs1_v, rs2_v, imm, op_b, alu;
    logic [4:0]  shamt;
    logic        eq, slt, ult, taken;
    logic [31:0] pc4, pcimm, target, npc;
    logic        misaligned;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    assign opcode = ir_q[6:0];
    assign func3  = ir_q[14:12];
    assign func7  = ir_q[30];
    assign rd     = ir_q[11:7];
    assign rs1_a  = ir_q[19:15];
    assign rs2_a  = ir_q[24:20];

    assign rs1_v = (rs1_a == 5'd0) ? 32'd0 : rf_q[rs1_a];
    assign rs2_v = (rs2_a == 5'd0) ? 32'd0 : rf_q[rs2_a];

    always_comb begin
        case (ir_q[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                imm = {{20{ir_q[31]}}, ir_q[31:20]};
            7'b0100011:
                imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            7'b1100011:
                imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm = {ir_q[31:12], 12'd0};
            7'b1101111:
                imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

    assign op_b  = ALUSrc ? imm : rs2_v;
    assign shamt = op_b[4:0];

    always_comb begin
        case (ALUctl)
            4'd1:    alu = rs1_v - op_b;
            4'd2:    alu = rs1_v & op_b;
            4'd3:    alu = rs1_v | op_b;
            4'd4:    alu = rs1_v ^ op_b;
            4'd5:    alu = {31'd0, $signed(rs1_v) < $signed(op_b)};
            4'd6:    alu = {31'd0, rs1_v < op_b};
            4'd7:    alu = rs1_v << shamt;
            4'd8:    alu = rs1_v >> shamt;
            4'd9:    alu = $signed(rs1_v) >>> shamt;
            default: alu = rs1_v + op_b;
        endcase
    end

    // Branch compare always uses the two register operands, independent of ALUSrc.
    assign eq    = (rs1_v == rs2_v);
    assign slt   = ($signed(rs1_v) < $signed(rs2_v));
    assign ult   = (rs1_v < rs2_v);
    assign taken = jal | (beq & eq) | (bne & ~eq) | (blt & slt) | (bge & ~slt)
                 | (bltu & ult) | (bgeu & ~ult);

    assign pc4        = pc_q + 32'd4;
    assign pcimm      = pc_q + imm;
    assign target     = jalr ? {alu[31:1], 1'b0} : (taken ? pcimm : pc4);
    assign misaligned = (target[1:0] != 2'b00);
    // With the trap disabled the low bits are simply dropped.
    assign npc        = MISALIGN_TRAP ? target : {target[31:2], 2'b00};

    // st_q keeps stores out of the register file whatever RegWrite says.
    assign rf_we = (state_q == S_WB) && RegWrite && !st_q && (rd != 5'd0);
    assign rf_wa = rd;
    assign rf_wd = U_type ? (lui ? imm : pcimm_q)
                 : (jal | jalr) ? pc4_q
                 : MemtoReg ? ld_q : alu_q;

    always_ff @(posedge clk) begin
        if (rf_we) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        alu_d     = alu_q;
        rs2_d     = rs2_q;
        pc4_d     = pc4_q;
        pcimm_d   = pcimm_q;
        npc_d     = npc_q;
        st_d      = st_q;
        ld_d      = ld_q;
        trap_pc_d = trap_pc_q;
        instret_d = instret_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (mem.imem_ack) begin
                    ir_d    = mem.imem_rdata;
                    state_d = S_EX;
                end
            end
            S_EX: begin
                alu_d   = alu;
                rs2_d   = rs2_v;
                pc4_d   = pc4;
                pcimm_d = pcimm;
                npc_d   = npc;
                st_d    = mem_write;
                if (MISALIGN_TRAP && misaligned) begin
                    trap_pc_d = pc_q;
                    state_d   = S_TRAP;
                end else if (mem_read || mem_write) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem.dmem_ack) begin
                    ld_d    = mem.dmem_rdata;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                pc_d      = npc_q;
                instret_d = instret_q + CNT_ONE;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                pc_d    = TRAP_PC;
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= IR_NOP;
            alu_q     <= 32'd0;
            rs2_q     <= 32'd0;
            pc4_q     <= 32'd0;
            pcimm_q   <= 32'd0;
            npc_q     <= 32'd0;
            st_q      <= 1'b0;
            ld_q      <= 32'd0;
            trap_pc_q <= 32'd0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            alu_q     <= alu_d;
            rs2_q     <= rs2_d;
            pc4_q     <= pc4_d;
            pcimm_q   <= pcimm_d;
            npc_q     <= npc_d;
            st_q      <= st_d;
            ld_q      <= ld_d;
            trap_pc_q <= trap_pc_d;
            instret_q <= instret_d;
        end
    end

    // Requests decode from state (and a state-time register) only, never from ack.
    assign mem.imem_req   = (state_q == S_FETCH);
    assign mem.imem_addr  = pc_q;
    assign mem.dmem_req   = (state_q == S_MEM);
    assign mem.dmem_we    = (state_q == S_MEM) && st_q;
    assign mem.dmem_addr  = alu_q;
    assign mem.dmem_wdata = rs2_q;

    assign trap    = (state_q == S_TRAP);
    assign trap_pc = trap_pc_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_datapath_mc.sv
`timescale 1ns/1ps
module tb_datapath_mc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic MemtoReg, ALUSrc, RegWrite, lui, U_type, jal, jalr;
    logic beq, bne, blt, bge, bltu, bgeu, mem_read, mem_write;
    logic [3:0]  ALUctl;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        func7;
    logic        trap;
    logic [31:0] trap_pc;
    logic [31:0] instret;

    datapath_mc_if mif();

    datapath_mc #(
        .RESET_PC(32'h0000_0000), .TRAP_PC(32'h0000_0100),
        .MISALIGN_TRAP(1'b1), .CNT_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .lui(lui), .U_type(U_type), .jal(jal), .jalr(jalr),
        .beq(beq), .bne(bne), .blt(blt), .bge(bge), .bltu(bltu), .bgeu(bgeu),
        .mem_read(mem_read), .mem_write(mem_write), .ALUctl(ALUctl),
        .opcode(opcode), .func3(func3), .func7(func7),
        .mem(mif),
        .trap(trap), .trap_pc(trap_pc), .instret(instret)
    );

    // ---------------- external decoder ----------------
    function automatic logic [3:0] alu_sel(logic [2:0] f3, logic f7, logic is_r);
        case (f3)
            3'd0:    return (is_r && f7) ? 4'd1 : 4'd0;
            3'd7:    return 4'd2;
            3'd6:    return 4'd3;
            3'd4:    return 4'd4;
            3'd2:    return 4'd5;
            3'd3:    return 4'd6;
            3'd1:    return 4'd7;
            default: return f7 ? 4'd9 : 4'd8;
        endcase
    endfunction

    always_comb begin
        MemtoReg = 0; ALUSrc = 0; RegWrite = 0; lui = 0; U_type = 0;
        jal = 0; jalr = 0; beq = 0; bne = 0; blt = 0; bge = 0; bltu = 0; bgeu = 0;
        mem_read = 0; mem_write = 0; ALUctl = 4'd0;
        case (opcode)
            7'b0010011: begin ALUSrc = 1; RegWrite = 1; ALUctl = alu_sel(func3, func7, 1'b0); end
            7'b0110011: begin RegWrite = 1; ALUctl = alu_sel(func3, func7, 1'b1); end
            7'b0000011: begin ALUSrc = 1; RegWrite = 1; MemtoReg = 1; mem_read = 1; end
            // RegWrite deliberately set on stores: the datapath must ignore it.
            7'b0100011: begin ALUSrc = 1; RegWrite = 1; mem_write = 1; end
            7'b1100011: begin
                beq  = (func3 == 3'd0); bne  = (func3 == 3'd1);
                blt  = (func3 == 3'd4); bge  = (func3 == 3'd5);
                bltu = (func3 == 3'd6); bgeu = (func3 == 3'd7);
                ALUctl = 4'd1;
            end
            7'b1101111: begin RegWrite = 1; jal = 1; end
            7'b1100111: begin RegWrite = 1; jalr = 1; ALUSrc = 1; end
            7'b0110111: begin RegWrite = 1; U_type = 1; lui = 1; end
            7'b0010111: begin RegWrite = 1; U_type = 1; end
            default: ;
        endcase
    end

    // ---------------- program and memory models ----------------
    function automatic logic [31:0] imem_word(logic [31:0] a);
        case (a)
            32'h000: return 32'h0050_0093; // addi x1,x0,5
            32'h004: return 32'h0010_2423; // sw   x1,8(x0)
            32'h008: return 32'h0080_2103; // lw   x2,8(x0)
            32'h00C: return 32'h0340_006F; // jal  x0,+0x34 -> 0x40
            32'h040: return 32'h0000_0863; // beq  x0,x0,+16 -> 0x50
            32'h050: return 32'h0080_00EF; // jal  x1,+8 -> 0x58
            32'h058: return 32'h0020_81B3; // add  x3,x1,x2
            32'h05C: return 32'h1234_5237; // lui  x4,0x12345
            32'h060: return 32'h0000_1297; // auipc x5,1
            32'h064: return 32'h4011_8333; // sub  x6,x3,x1
            32'h068: return 32'h0023_1463; // bne  x6,x2,+8 (not taken)
            32'h06C: return 32'h0013_6463; // bltu x6,x1,+8 (taken)
            32'h074: return 32'h0020_0067; // jalr x0,2(x0) -> misaligned
            32'h100: return 32'h0010_0393; // addi x7,x0,1
            32'h104: return 32'h0070_2623; // sw   x7,12(x0)
            default: return 32'h0000_0013;
        endcase
    endfunction

    function automatic int imem_wait(logic [31:0] a);
        return (a == 32'h058) ? 3 : 0;
    endfunction

    function automatic int dmem_wait(logic [31:0] a);
        return (a == 32'd12) ? 1000 : 2;
    endfunction

    logic [31:0] dmem [16];
    int  icnt = 0, dcnt = 0;
    logic late_dack = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            icnt = 0; dcnt = 0;
            mif.imem_ack = 1'b0;
            mif.dmem_ack = late_dack;
        end else begin
            if (mif.imem_req) begin
                if (icnt >= imem_wait(mif.imem_addr)) begin
                    mif.imem_ack   = 1'b1;
                    mif.imem_rdata = imem_word(mif.imem_addr);
                end else begin
                    mif.imem_ack   = 1'b0;
                    mif.imem_rdata = 32'hFFFF_FFFF;
                    icnt++;
                end
            end else begin
                mif.imem_ack   = 1'b0;
                mif.imem_rdata = 32'hFFFF_FFFF;
                icnt = 0;
            end
            if (late_dack) begin
                mif.dmem_ack = 1'b1;
            end else if (mif.dmem_req) begin
                if (dcnt >= dmem_wait(mif.dmem_addr)) begin
                    mif.dmem_ack = 1'b1;
                    if (mif.dmem_we) dmem[mif.dmem_addr[5:2]] = mif.dmem_wdata;
                    mif.dmem_rdata = dmem[mif.dmem_addr[5:2]];
                end else begin
                    mif.dmem_ack = 1'b0;
                    dcnt++;
                end
            end else begin
                mif.dmem_ack = 1'b0;
                dcnt = 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic flag(string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
    endtask

    typedef struct { logic [31:0] addr; int lat; } fexp_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } wexp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } dexp_t;

    fexp_t fq[$];
    wexp_t wq[$];
    dexp_t dq[$];

    // fetch monitor: address order, per-instruction latency, hold during waits
    logic        prev_req = 1'b0;
    logic        have_start = 1'b0;
    int          start_cyc = 0, exp_lat = 0, hold = 0;
    logic [31:0] held_addr = '0;
    logic [6:0]  op_before = '0;
    logic [31:0] fword;
    always begin
        @(negedge clk); #1;
        if (!rst_n) begin
            prev_req = 1'b0; have_start = 1'b0;
        end else begin
            if (mif.imem_req && !prev_req) begin
                if (have_start && exp_lat != 0) check("fetch_latency", cyc - start_cyc, exp_lat);
                if (fq.size() == 0) flag("fetch_unexpected");
                else begin
                    fexp_t e;
                    e = fq.pop_front();
                    check("fetch_addr", mif.imem_addr, e.addr);
                    exp_lat = e.lat;
                end
                start_cyc = cyc; have_start = 1'b1;
                held_addr = mif.imem_addr; op_before = opcode; hold = 0;
            end
            if (mif.imem_req) begin
                hold++;
                check("fetch_addr_hold", mif.imem_addr, held_addr);
                if (!mif.imem_ack) check("ir_before_ack", {25'd0, opcode}, {25'd0, op_before});
            end
            if (prev_req && !mif.imem_req) begin
                fword = imem_word(held_addr);
                check("ir_loaded", {25'd0, opcode}, {25'd0, fword[6:0]});
                check("fetch_req_cycles", hold, imem_wait(held_addr) + 1);
            end
            prev_req = mif.imem_req;
        end
    end

    // register write-back monitor
    always begin
        @(negedge clk); #1;
        if (rst_n && dut.rf_we) begin
            if (wq.size() == 0) flag("wb_unexpected");
            else begin
                wexp_t e;
                e = wq.pop_front();
                check("wb_rd", {27'd0, dut.rf_wa}, {27'd0, e.rd});
                check("wb_data", dut.rf_wd, e.data);
            end
        end
    end

    // data-bus monitor: compares every request cycle, pops on ack
    always begin
        @(negedge clk); #1;
        if (rst_n && mif.dmem_req) begin
            if (dq.size() == 0) flag("dmem_unexpected");
            else begin
                check("dmem_we", {31'd0, mif.dmem_we}, {31'd0, dq[0].we});
                check("dmem_addr", mif.dmem_addr, dq[0].addr);
                if (dq[0].we) check("dmem_wdata", mif.dmem_wdata, dq[0].wdata);
                if (mif.dmem_ack) void'(dq.pop_front());
            end
        end
    end

    // trap monitor
    int trap_cnt = 0;
    always begin
        @(negedge clk); #1;
        if (rst_n && trap) begin
            trap_cnt++;
            check("trap_pc", trap_pc, 32'h74);
            check("trap_instret", instret, 32'd12);
        end
    end

    task automatic wait_for_wb(int budget, string nm);
        int n;
        n = 0;
        while (!dut.rf_we && n < budget) begin @(negedge clk); #1; n++; end
        if (!dut.rf_we) flag(nm);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        mif.imem_ack = 1'b0; mif.imem_rdata = 32'hFFFF_FFFF;
        mif.dmem_ack = 1'b0; mif.dmem_rdata = 32'd0;
        for (int i = 0; i < 16; i++) dmem[i] = 32'd0;

        fq.push_back('{32'h000, 3}); fq.push_back('{32'h004, 6});
        fq.push_back('{32'h008, 6}); fq.push_back('{32'h00C, 3});
        fq.push_back('{32'h040, 3}); fq.push_back('{32'h050, 3});
        fq.push_back('{32'h058, 6}); fq.push_back('{32'h05C, 3});
        fq.push_back('{32'h060, 3}); fq.push_back('{32'h064, 3});
        fq.push_back('{32'h068, 3}); fq.push_back('{32'h06C, 3});
        fq.push_back('{32'h074, 3}); fq.push_back('{32'h100, 3});
        fq.push_back('{32'h104, 0});

        wq.push_back('{5'd1, 32'd5});        wq.push_back('{5'd2, 32'd5});
        wq.push_back('{5'd1, 32'h54});       wq.push_back('{5'd3, 32'h59});
        wq.push_back('{5'd4, 32'h1234_5000}); wq.push_back('{5'd5, 32'h1060});
        wq.push_back('{5'd6, 32'd5});        wq.push_back('{5'd7, 32'd1});

        dq.push_back('{1'b1, 32'd8, 32'd5});
        dq.push_back('{1'b0, 32'd8, 32'd0});
        dq.push_back('{1'b1, 32'd12, 32'd1});

        repeat (3) @(posedge clk);
        #1;
        check("rst_imem_req", {31'd0, mif.imem_req}, 32'd0);
        check("rst_dmem_req", {31'd0, mif.dmem_req}, 32'd0);
        check("rst_dmem_we", {31'd0, mif.dmem_we}, 32'd0);
        check("rst_trap", {31'd0, trap}, 32'd0);
        check("rst_trap_pc", trap_pc, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_pc", mif.imem_addr, 32'd0);
        check("rst_ir_opcode", {25'd0, opcode}, 32'h13);

        rst_n = 1'b1;
        #1;
        check("idle_no_req", {31'd0, mif.imem_req}, 32'd0);
        @(posedge clk); #1;
        check("first_req", {31'd0, mif.imem_req}, 32'd1);
        check("first_addr", mif.imem_addr, 32'd0);

        @(negedge clk); #1;
        wait_for_wb(20, "first_wb_timeout");
        check("wb1_instret_before", instret, 32'd0);
        @(negedge clk); #1;
        check("wb1_instret_after", instret, 32'd1);
        check("wb1_next_addr", mif.imem_addr, 32'd4);

        begin
            int n;
            n = 0;
            while (!(mif.dmem_req && mif.dmem_addr == 32'd12) && n < 400) begin
                @(negedge clk); #1; n++;
            end
            if (!(mif.dmem_req && mif.dmem_addr == 32'd12)) flag("reach_final_store_timeout");
        end
        check("instret_before_reset", instret, 32'd13);

        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_dmem_req", {31'd0, mif.dmem_req}, 32'd0);
        check("mid_rst_dmem_we", {31'd0, mif.dmem_we}, 32'd0);
        check("mid_rst_pc", mif.imem_addr, 32'd0);
        check("mid_rst_instret", instret, 32'd0);
        check("mid_rst_opcode", {25'd0, opcode}, 32'h13);
        dq.delete();
        fq.push_back('{32'h000, 3});
        fq.push_back('{32'h004, 0});
        wq.push_back('{5'd1, 32'd5});
        late_dack = 1'b1;

        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        begin
            int n;
            n = 0;
            while (!(mif.imem_req && mif.imem_addr == 32'd4) && n < 20) begin
                @(negedge clk); #1; n++;
            end
            if (!(mif.imem_req && mif.imem_addr == 32'd4)) flag("restart_timeout");
        end
        check("restart_instret", instret, 32'd1);
        late_dack = 1'b0;

        @(negedge clk); #2;
        check("wq_drained", wq.size(), 32'd0);
        check("fq_drained", fq.size(), 32'd0);
        check("trap_pulse_count", trap_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/datapath_mc.md
DATAPATH_MC -- requirements
Module: datapath_mc

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000: PC loaded on reset.
REQ-002 Parameter TRAP_PC, 32'h0000_0100: PC loaded on misaligned-target trap.
REQ-003 Parameter MISALIGN_TRAP, 1: 1 enables the trap; 0 forces target bit[1:0] to 2'b00.
REQ-004 Parameter CNT_W, 32: width of the retired-instruction counter.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 MemtoReg, ALUSrc, RegWrite, lui, U_type, jal, jalr, beq, bne, blt, bge, bltu, bgeu  in  1 each  decoded controls, valid while state is EX, MEM or WB.
REQ-008 mem_read, mem_write  in  1 each  instruction is a load or store; mutually exclusive.
REQ-009 ALUctl  in  4  ALU operation select.
REQ-010 opcode  out  7, func3  out  3, func7  out  1  fields of the latched instruction register (IR).
REQ-011 imem_req  out  1; imem_addr  out  32; imem_rdata  in  32; imem_ack  in  1  instruction fetch handshake.
REQ-012 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32; dmem_wdata  out  32; dmem_rdata  in  32; dmem_ack  in  1  data handshake.
REQ-013 trap  out  1  one-cycle pulse on a misaligned-target trap; trap_pc  out  32  PC of the faulting instruction.
REQ-014 instret  out  CNT_W  count of retired instructions.

Function
REQ-015 States: IDLE, FETCH, EX, MEM, WB, TRAP; one-hot or binary encoding is free.
REQ-016 IDLE->FETCH unconditionally after one cycle.
REQ-017 FETCH: imem_req=1, imem_addr=PC; on imem_ack, IR<=imem_rdata, ->EX; otherwise remain in FETCH with address held stable.
REQ-018 EX: decode IR; ALU A=rs1, B=imm if ALUSrc else rs2; latch ALU result, rs2, PC+4, PC+imm and the branch decision; compute next PC as: jalr ? {alu[31:1],0} : taken ? PC+imm : PC+4.
REQ-019 EX exit: misaligned target (next PC[1:0]!=0) with MISALIGN_TRAP=1 ->TRAP; else mem_read|mem_write ->MEM; else ->WB.
REQ-020 MEM: dmem_req=1, dmem_we=mem_write, dmem_addr=latched ALU result, dmem_wdata=latched rs2; on dmem_ack latch dmem_rdata (loads), ->WB; otherwise hold all outputs stable.
REQ-021 WB write data: U_type ? (lui ? imm : PC+imm) : (jal|jalr) ? PC+4 : MemtoReg ? load data : ALU result.
REQ-022 WB: register write enable = RegWrite for exactly this one cycle; PC<=next PC; instret+=1; ->FETCH.
REQ-023 Register writes occur only in WB; x0 reads as 0 and writes to it are discarded.
REQ-024 TRAP: no register write, instret unchanged, trap=1, trap_pc<=faulting PC, PC<=TRAP_PC, ->FETCH.
REQ-025 Latency with zero-wait acks: ALU/branch/jump 3 cycles (FETCH, EX, WB); load/store 4 cycles; trap 3 cycles.
REQ-026 imem_ack outside FETCH and dmem_ack outside MEM are ignored.
REQ-027 A store never writes the register file, even if RegWrite=1.
REQ-028 instret wraps from 2^CNT_W-1 to 0.
REQ-029 imem_req, dmem_req and dmem_we are combinational from state only; they never depend on ack within the same cycle.

Reset
REQ-030 rst_n low forces immediately: state=IDLE, PC=RESET_PC, IR=32'h0000_0013, instret=0, trap=0, trap_pc=0, imem_req=0, dmem_req=0, dmem_we=0.
REQ-031 Reset asserted mid-handshake drops the request immediately; no register write or instret increment completes, and a late ack after release is ignored.
REQ-032 The register file contents are not reset.
REQ-033 First imem_req assertion is in the second cycle after rst_n rises, with imem_addr=RESET_PC.

Verification
REQ-034 Reset release, imem_ack tied 1, instruction addi x1,x0,5 (32'h0050_0093) -> x1=5 in the WB cycle, instret=1, next imem_addr=RESET_PC+4.
REQ-035 imem_ack delayed 3 cycles -> imem_req and imem_addr held constant for 4 cycles; IR loaded only on the ack cycle.
REQ-036 sw x1,8(x0) then lw x2,8(x0), dmem_ack delayed 2 cycles -> store issues dmem_we=1, addr=8, wdata=5; load writes x2=5; each instruction takes 6 cycles.
REQ-037 beq x0,x0,+16 at PC=0x40 -> next fetch at 0x50; jal x1,+8 at 0x50 -> x1=0x54, next fetch at 0x58.
REQ-038 jalr x0,2(x0) with MISALIGN_TRAP=1 -> trap pulses 1 cycle, trap_pc=faulting PC, next fetch at 0x100, instret unchanged.
REQ-039 rst_n dropped during MEM with dmem_req=1 -> dmem_req=0 in the same cycle, no register write, PC=RESET_PC.
